alu_rr_scheduler: RTL and testbench
===================================

Name: alu_rr_scheduler

Overview:
- Shares one 8-bit ALU datapath between NUM_REQ requesters using round-robin arbitration.
- Captures the winner's operands and opcode, executes one registered ALU cycle, then holds a tagged 16-bit result until the consumer accepts it.
- Sits between the requester ports and the ALU instance (module ALU: a, b, opcode, out), which it instantiates.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ID_W, 2, requester tag width; must satisfy 2**ID_W >= NUM_REQ.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- req_valid  in  NUM_REQ  per-requester operation valid.
- req_ready  out  NUM_REQ  per-requester accept; one-hot or zero.
- req_a  in  8*NUM_REQ  operand a; requester i occupies bits [8i+7:8i].
- req_b  in  8*NUM_REQ  operand b; same packing as req_a.
- req_op  in  4*NUM_REQ  opcode; requester i occupies bits [4i+3:4i].
- rsp_valid  out  1  result valid.
- rsp_ready  in  1  consumer accepts the result.
- rsp_data  out  16  ALU result.
- rsp_id  out  ID_W  index of the requester that issued the result.

Behaviour:
- Reset: asynchronous and active-high. One clock, clk. On reset: state=IDLE, rsp_valid=0, rsp_data=0, rsp_id=0, req_ready=0, rr pointer=0, operand registers=0.
- State IDLE:
  - Search for the first asserted req_valid starting at index ptr, wrapping modulo NUM_REQ.
  - If one is found, req_ready[winner]=1 combinationally in that cycle. Latch a, b, op and winner id. Set ptr=(winner+1) mod NUM_REQ. Go to EXEC.
  - If none is found, req_ready=0 and the block stays in IDLE.
- State EXEC:
  - The latched operands drive the ALU.
  - rsp_data <= ALU out, or the substitute below for divide-by-zero. rsp_id <= latched id.
  - rsp_valid <= 1. Go to RESP.
- State RESP:
  - rsp_valid, rsp_data and rsp_id are held stable until rsp_valid && rsp_ready.
  - On acceptance: rsp_valid <= 0, go to IDLE.
  - No new grant is issued in RESP or EXEC; req_ready=0 in both.
- Latency:
  - Grant cycle T. rsp_valid is high from T+2.
  - Minimum issue interval is 3 cycles, with rsp_ready tied high.
- Requester handshake:
  - A transfer occurs only when req_valid[i] && req_ready[i].
  - A requester may drop valid before it is granted; its slot is simply skipped.
  - A requester that is not granted keeps its request pending; there is no starvation, since at most NUM_REQ-1 grants occur before its turn.
- ALU result rules (16-bit result context):
  - 0000 a+b, zero-extended.
  - 0001 a-b, mod 2^16 (3-5 = 16'hFFFE).
  - 0010 a*b.
  - 0011 a/b.
  - 0100 {a,b}.
  - 0101 a<<2, no truncation (8'hFF -> 16'h03FC).
  - 0110 a>>2.
  - 0111 0.
  - 1000 and.
  - 1001 or.
  - 1010 nand, upper byte 8'hFF.
  - 1011 nor, upper byte 8'hFF.
  - 1100 xor.
  - 1101 xnor, upper byte 8'hFF.
  - 1110 and 1111 give 0.
- Divide-by-zero: op=0011 with b=0 never forwards the ALU output; the substitute is defined under Optional Feature.
- Simultaneous events:
  - rsp_ready asserted while rsp_valid=0 is ignored.
  - req_valid that is all-zero in IDLE means no state change.
- Reset mid-operation: any in-flight operation is discarded and the pointer returns to 0; no response is produced for it.

Optional Feature:
- Macro: ALU_DIVZERO_ERR_EN.
- Defined:
  - Adds output port rsp_err (1 bit), registered alongside rsp_data and reset to 0.
  - On divide-by-zero: rsp_data=16'hFFFF and rsp_err=1. Otherwise rsp_err=0.
- Undefined:
  - No rsp_err port exists.
  - On divide-by-zero: rsp_data=16'h0000.
  - All other behaviour is identical in both builds.

Test Plan:
- Single requester: req 0 sends a=8'd3, b=8'd5, op=0001, rsp_ready=1 -> req_ready[0] high for one cycle, rsp_valid 2 cycles later, rsp_data=16'hFFFE, rsp_id=0.
- Round-robin: all 4 valid continuously, op=0000, a=i, b=1 -> grant order 0,1,2,3,0; rsp_data 1,2,3,4,1; each grant spaced 3 cycles.
- Backpressure: rsp_ready=0 for 5 cycles after rsp_valid (req 2, a=8'hFF, op=0101) -> rsp_data=16'h03FC and rsp_id=2 held stable; no req_ready during the stall; IDLE is re-entered the cycle after rsp_ready=1.
- Width rules: req 1 issues a=8'hF0, b=8'h0F, op=1101 -> 16'hFF00; then op=0100 -> 16'hF00F; then op=0010 with a=b=8'hFF -> 16'hFE01.
- Divide-by-zero: a=8'd9, b=0, op=0011 -> rsp_data=16'hFFFF and rsp_err=1 with ALU_DIVZERO_ERR_EN; rsp_data=16'h0000 without. Then a=9, b=2 -> 16'h0004 (rsp_err=0).
- Reset mid-op: assert rst during EXEC of a grant to req 3 -> rsp_valid stays 0, no response emitted; after release, with reqs 1 and 3 valid, req 1 wins first (ptr=0).

Source files
------------

// File: rtl/alu_rr_scheduler.sv
// ---------------------------------------------------------------------------
// alu_rr_scheduler
//   Shares one 8-bit ALU between NUM_REQ requesters. A round-robin arbiter
//   grants one request, the winner's operands are captured, the ALU result is
//   registered one cycle later together with the requester tag, and the
//   response is held until the consumer accepts it.
//
//   Optional build macro: ALU_DIVZERO_ERR_EN
//     defined   : adds rsp_err; divide-by-zero returns 16'hFFFF with rsp_err=1
//     undefined : no rsp_err; divide-by-zero returns 16'h0000
//
// Ports
//   clk        in   system clock, rising edge
//   rst        in   asynchronous active-high reset
//   req_valid  in   [NUM_REQ]     per-requester operation valid
//   req_ready  out  [NUM_REQ]     per-requester accept, one-hot or zero
//   req_a      in   [8*NUM_REQ]   operand a, requester i at [8i+7:8i]
//   req_b      in   [8*NUM_REQ]   operand b, same packing
//   req_op     in   [4*NUM_REQ]   opcode, requester i at [4i+3:4i]
//   rsp_valid  out  result valid
//   rsp_ready  in   consumer accepts result
//   rsp_data   out  [16]   result
//   rsp_id     out  [ID_W] issuing requester index
//   rsp_err    out  divide-by-zero flag (only with ALU_DIVZERO_ERR_EN)
// ---------------------------------------------------------------------------

// Combinational 8-bit ALU producing a 16-bit result.
//   a, b   : operands
//   opcode : operation select
//   out    : 16-bit result (divide by zero yields 0 here; the scheduler
//            substitutes its own value for that case)
module ALU (
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    input  logic [3:0]  opcode,
    output logic [15:0] out
);

    // Operation decode; inverting logic ops fill the upper byte with ones.
    always_comb begin
        out = 16'h0000;
        case (opcode)
            4'b0000: out = {8'h00, a} + {8'h00, b};
            4'b0001: out = {8'h00, a} - {8'h00, b};
            4'b0010: out = {8'h00, a} * {8'h00, b};
            4'b0011: begin
                if (b == 8'h00) begin
                    out = 16'h0000;
                end else begin
                    out = {8'h00, a / b};
                end
            end
            4'b0100: out = {a, b};
            4'b0101: out = {8'h00, a} << 2;
            4'b0110: out = {8'h00, a >> 2};
            4'b0111: out = 16'h0000;
            4'b1000: out = {8'h00, a & b};
            4'b1001: out = {8'h00, a | b};
            4'b1010: out = {8'hFF, ~(a & b)};
            4'b1011: out = {8'hFF, ~(a | b)};
            4'b1100: out = {8'h00, a ^ b};
            4'b1101: out = {8'hFF, ~(a ^ b)};
            default: out = 16'h0000;
        endcase
    end

endmodule

module alu_rr_scheduler #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req_valid,
    output logic [NUM_REQ-1:0]   req_ready,
    input  logic [8*NUM_REQ-1:0] req_a,
    input  logic [8*NUM_REQ-1:0] req_b,
    input  logic [4*NUM_REQ-1:0] req_op,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [15:0]          rsp_data,
    output logic [ID_W-1:0]      rsp_id
`ifdef ALU_DIVZERO_ERR_EN
    ,
    output logic                 rsp_err
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t            state_r;
    logic [ID_W-1:0]   ptr_r;
    logic [7:0]        a_r;
    logic [7:0]        b_r;
    logic [3:0]        op_r;
    logic [ID_W-1:0]   id_r;
    logic              rsp_valid_r;
    logic [15:0]       rsp_data_r;
    logic [ID_W-1:0]   rsp_id_r;
`ifdef ALU_DIVZERO_ERR_EN
    logic              rsp_err_r;
`endif

    logic              found_s;
    logic [ID_W-1:0]   winner_s;
    logic [ID_W-1:0]   next_ptr_s;
    logic              grant_s;
    logic [NUM_REQ-1:0] ready_s;
    logic [15:0]       alu_out_s;
    logic              divzero_s;
    logic [15:0]       result_s;

    // Round-robin search: first valid request at or after ptr_r, wrapping.
    always_comb begin
        int idx_v;
        idx_v    = 0;
        found_s  = 1'b0;
        winner_s = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx_v = int'(ptr_r) + k;
            if (idx_v >= NUM_REQ) begin
                idx_v = idx_v - NUM_REQ;
            end else begin
                idx_v = idx_v;
            end
            if (!found_s && req_valid[ID_W'(idx_v)]) begin
                found_s  = 1'b1;
                winner_s = ID_W'(idx_v);
            end else begin
                found_s  = found_s;
            end
        end
    end

    // Grant only in IDLE and never while reset is held; the winner's valid is
    // already high, so a grant is always a completed transfer.
    always_comb begin
        grant_s = found_s && (state_r == IDLE) && !rst;
        ready_s = '0;
        if (grant_s) begin
            ready_s[winner_s] = 1'b1;
        end else begin
            ready_s = '0;
        end
    end

    // Pointer moves to the slot after the winner, modulo NUM_REQ.
    always_comb begin
        if (int'(winner_s) == NUM_REQ - 1) begin
            next_ptr_s = '0;
        end else begin
            next_ptr_s = winner_s + ID_W'(1);
        end
    end

    ALU u_alu (
        .a      (a_r),
        .b      (b_r),
        .opcode (op_r),
        .out    (alu_out_s)
    );

    // Divide-by-zero never forwards the ALU output.
    always_comb begin
        divzero_s = (op_r == 4'b0011) && (b_r == 8'h00);
        if (divzero_s) begin
`ifdef ALU_DIVZERO_ERR_EN
            result_s = 16'hFFFF;
`else
            result_s = 16'h0000;
`endif
        end else begin
            result_s = alu_out_s;
        end
    end

    // Scheduler FSM: capture on grant, register result, hold until accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= IDLE;
            ptr_r       <= '0;
            a_r         <= 8'h00;
            b_r         <= 8'h00;
            op_r        <= 4'h0;
            id_r        <= '0;
            rsp_valid_r <= 1'b0;
            rsp_data_r  <= 16'h0000;
            rsp_id_r    <= '0;
`ifdef ALU_DIVZERO_ERR_EN
            rsp_err_r   <= 1'b0;
`endif
        end else begin
            case (state_r)
                IDLE: begin
                    if (grant_s) begin
                        a_r     <= req_a[{winner_s, 3'b000} +: 8];
                        b_r     <= req_b[{winner_s, 3'b000} +: 8];
                        op_r    <= req_op[{winner_s, 2'b00} +: 4];
                        id_r    <= winner_s;
                        ptr_r   <= next_ptr_s;
                        state_r <= EXEC;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                EXEC: begin
                    rsp_data_r  <= result_s;
                    rsp_id_r    <= id_r;
                    rsp_valid_r <= 1'b1;
`ifdef ALU_DIVZERO_ERR_EN
                    rsp_err_r   <= divzero_s;
`endif
                    state_r     <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_r <= 1'b0;
                        state_r     <= IDLE;
                    end else begin
                        state_r     <= RESP;
                    end
                end
                default: begin
                    rsp_valid_r <= 1'b0;
                    state_r     <= IDLE;
                end
            endcase
        end
    end

    assign req_ready = ready_s;
    assign rsp_valid = rsp_valid_r;
    assign rsp_data  = rsp_data_r;
    assign rsp_id    = rsp_id_r;
`ifdef ALU_DIVZERO_ERR_EN
    assign rsp_err   = rsp_err_r;
`endif

endmodule

// File: tb/tb_alu_rr_scheduler.sv
// ---------------------------------------------------------------------------
// tb_alu_rr_scheduler
//   Directed self-checking bench for alu_rr_scheduler (NUM_REQ=4, ID_W=2).
//   Inputs are driven on the falling edge; outputs are sampled 1 ns later.
//   Honours ALU_DIVZERO_ERR_EN to match the build under test.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_alu_rr_scheduler;

    localparam int NUM_REQ = 4;
    localparam int ID_W    = 2;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic [NUM_REQ-1:0]   req_valid = '0;
    logic [NUM_REQ-1:0]   req_ready;
    logic [8*NUM_REQ-1:0] req_a = '0;
    logic [8*NUM_REQ-1:0] req_b = '0;
    logic [4*NUM_REQ-1:0] req_op = '0;
    logic                 rsp_valid;
    logic                 rsp_ready = 1'b0;
    logic [15:0]          rsp_data;
    logic [ID_W-1:0]      rsp_id;
`ifdef ALU_DIVZERO_ERR_EN
    logic                 rsp_err;
`endif

    int vectors = 0;
    int errors  = 0;
    int cyc     = 0;

    alu_rr_scheduler #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_op    (req_op),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_id    (rsp_id)
`ifdef ALU_DIVZERO_ERR_EN
        ,
        .rsp_err   (rsp_err)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic set_req(input int i, input logic [7:0] a, input logic [7:0] b,
                           input logic [3:0] op);
        req_a[8*i +: 8]  = a;
        req_b[8*i +: 8]  = b;
        req_op[4*i +: 4] = op;
    endtask

    // Leaves the bench just after a falling edge with reset released.
    task automatic do_reset();
        rst       = 1'b1;
        req_valid = '0;
        rsp_ready = 1'b0;
        req_a     = '0;
        req_b     = '0;
        req_op    = '0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Polls req_ready for up to 20 cycles; who=-1 on timeout. Returns 1 ns
    // after the falling edge of the grant cycle.
    task automatic wait_grant(output int who, output int at_cyc);
        who    = -1;
        at_cyc = -1;
        for (int c = 0; c < 20; c++) begin
            #1;
            if (req_ready != '0) begin
                for (int j = 0; j < NUM_REQ; j++) begin
                    if (req_ready[j]) who = j;
                end
                at_cyc = cyc;
                return;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        req_valid = 4'b1111;
        rsp_ready = 1'b1;
        @(negedge clk);
        #1;
        vectors++;
        if (rsp_valid !== 1'b0 || rsp_data !== 16'h0000 || rsp_id !== 2'd0 || req_ready !== 4'b0000) begin
            errors++;
            $display("FAIL reset_state: valid=%b data=%h id=%0d ready=%b, required 0/0000/0/0000",
                     rsp_valid, rsp_data, rsp_id, req_ready);
        end
`ifdef ALU_DIVZERO_ERR_EN
        vectors++;
        if (rsp_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_err: got %b, required 0", rsp_err);
        end
`endif
    endtask

    task automatic test_single();
        int who, t;
        do_reset();
        set_req(0, 8'd3, 8'd5, 4'b0001);
        rsp_ready = 1'b1;
        req_valid = 4'b0001;
        wait_grant(who, t);
        vectors++;
        if (who !== 0) begin
            errors++;
            $display("FAIL single_grant: got %0d, required 0", who);
        end
        @(negedge clk);
        req_valid = 4'b0000;
        #1;
        vectors++;
        if (req_ready !== 4'b0000 || rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_exec: ready=%b valid=%b, required 0000/0", req_ready, rsp_valid);
        end
        @(negedge clk);
        #1;
        vectors++;
        if (rsp_valid !== 1'b1 || rsp_data !== 16'hFFFE || rsp_id !== 2'd0) begin
            errors++;
            $display("FAIL single_rsp: valid=%b data=%h id=%0d, required 1/fffe/0",
                     rsp_valid, rsp_data, rsp_id);
        end
        @(negedge clk);
        #1;
        vectors++;
        if (rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_accept: valid=%b, required 0", rsp_valid);
        end
    endtask

    task automatic test_round_robin();
        int who, t, prev_t;
        do_reset();
        for (int i = 0; i < NUM_REQ; i++) set_req(i, 8'(i), 8'd1, 4'b0000);
        rsp_ready = 1'b1;
        req_valid = 4'b1111;
        prev_t = -1;
        for (int g = 0; g < 5; g++) begin
            wait_grant(who, t);
            vectors++;
            if (who !== (g % NUM_REQ)) begin
                errors++;
                $display("FAIL rr_order[%0d]: got %0d, required %0d", g, who, g % NUM_REQ);
            end
            if (g > 0) begin
                vectors++;
                if (t - prev_t !== 3) begin
                    errors++;
                    $display("FAIL rr_spacing[%0d]: got %0d cycles, required 3", g, t - prev_t);
                end
            end
            prev_t = t;
            @(negedge clk);
            @(negedge clk);
            #1;
            vectors++;
            if (rsp_valid !== 1'b1 || rsp_data !== 16'((g % NUM_REQ) + 1) || rsp_id !== 2'(g % NUM_REQ)) begin
                errors++;
                $display("FAIL rr_rsp[%0d]: valid=%b data=%h id=%0d, required 1/%h/%0d",
                         g, rsp_valid, rsp_data, rsp_id, 16'((g % NUM_REQ) + 1), g % NUM_REQ);
            end
            @(negedge clk);
        end
        req_valid = 4'b0000;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic test_back_to_back_stall();
        int who, t;
        do_reset();
        set_req(2, 8'hFF, 8'h00, 4'b0101);
        set_req(0, 8'h01, 8'h01, 4'b0000);
        rsp_ready = 1'b0;
        req_valid = 4'b0100;
        wait_grant(who, t);
        vectors++;
        if (who !== 2) begin
            errors++;
            $display("FAIL stall_grant: got %0d, required 2", who);
        end
        @(negedge clk);
        req_valid = 4'b0001;   // requester 0 waits through the stall
        @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            #1;
            vectors++;
            if (rsp_valid !== 1'b1 || rsp_data !== 16'h03FC || rsp_id !== 2'd2 || req_ready !== 4'b0000) begin
                errors++;
                $display("FAIL stall_hold[%0d]: valid=%b data=%h id=%0d ready=%b, required 1/03fc/2/0000",
                         k, rsp_valid, rsp_data, rsp_id, req_ready);
            end
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        #1;
        vectors++;
        if (rsp_valid !== 1'b1 || rsp_data !== 16'h03FC || req_ready !== 4'b0000) begin
            errors++;
            $display("FAIL stall_accept: valid=%b data=%h ready=%b, required 1/03fc/0000",
                     rsp_valid, rsp_data, req_ready);
        end
        @(negedge clk);
        #1;
        vectors++;
        if (rsp_valid !== 1'b0 || req_ready !== 4'b0001) begin
            errors++;
            $display("FAIL stall_idle: valid=%b ready=%b, required 0/0001", rsp_valid, req_ready);
        end
        @(negedge clk);
        req_valid = 4'b0000;
        @(negedge clk);
        @(negedge clk);
    endtask

    // Runs a table of single-requester ops on requester 1 and checks results.
    task automatic test_width_and_divzero();
        logic [7:0]  a_t   [5];
        logic [7:0]  b_t   [5];
        logic [3:0]  op_t  [5];
        logic [15:0] exp_t [5];
        logic        err_t [5];
        int who, t;
        a_t[0] = 8'hF0; b_t[0] = 8'h0F; op_t[0] = 4'b1101; exp_t[0] = 16'hFF00; err_t[0] = 1'b0;
        a_t[1] = 8'hF0; b_t[1] = 8'h0F; op_t[1] = 4'b0100; exp_t[1] = 16'hF00F; err_t[1] = 1'b0;
        a_t[2] = 8'hFF; b_t[2] = 8'hFF; op_t[2] = 4'b0010; exp_t[2] = 16'hFE01; err_t[2] = 1'b0;
`ifdef ALU_DIVZERO_ERR_EN
        a_t[3] = 8'd9;  b_t[3] = 8'd0;  op_t[3] = 4'b0011; exp_t[3] = 16'hFFFF; err_t[3] = 1'b1;
`else
        a_t[3] = 8'd9;  b_t[3] = 8'd0;  op_t[3] = 4'b0011; exp_t[3] = 16'h0000; err_t[3] = 1'b0;
`endif
        a_t[4] = 8'd9;  b_t[4] = 8'd2;  op_t[4] = 4'b0011; exp_t[4] = 16'h0004; err_t[4] = 1'b0;
        do_reset();
        rsp_ready = 1'b1;
        for (int n = 0; n < 5; n++) begin
            set_req(1, a_t[n], b_t[n], op_t[n]);
            req_valid = 4'b0010;
            wait_grant(who, t);
            vectors++;
            if (who !== 1) begin
                errors++;
                $display("FAIL op_grant[%0d]: got %0d, required 1", n, who);
            end
            @(negedge clk);
            req_valid = 4'b0000;
            @(negedge clk);
            #1;
            vectors++;
            if (rsp_valid !== 1'b1 || rsp_data !== exp_t[n] || rsp_id !== 2'd1) begin
                errors++;
                $display("FAIL op_rsp[%0d]: valid=%b data=%h id=%0d, required 1/%h/1",
                         n, rsp_valid, rsp_data, rsp_id, exp_t[n]);
            end
`ifdef ALU_DIVZERO_ERR_EN
            vectors++;
            if (rsp_err !== err_t[n]) begin
                errors++;
                $display("FAIL op_err[%0d]: got %b, required %b", n, rsp_err, err_t[n]);
            end
`else
            if (err_t[n] !== 1'b0) $display("note: unexpected err entry %0d", n);
`endif
            @(negedge clk);
        end
    endtask

    task automatic test_reset_mid_op();
        int who, t;
        do_reset();
        set_req(3, 8'd7, 8'd7, 4'b0000);
        req_valid = 4'b1000;
        rsp_ready = 1'b1;
        wait_grant(who, t);
        vectors++;
        if (who !== 3) begin
            errors++;
            $display("FAIL midrst_grant: got %0d, required 3", who);
        end
        @(negedge clk);          // EXEC cycle
        req_valid = 4'b0000;
        #1;
        rst = 1'b1;
        #2;
        vectors++;
        if (rsp_valid !== 1'b0 || req_ready !== 4'b0000) begin
            errors++;
            $display("FAIL midrst_async: valid=%b ready=%b, required 0/0000", rsp_valid, req_ready);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            #1;
            vectors++;
            if (rsp_valid !== 1'b0) begin
                errors++;
                $display("FAIL midrst_norsp[%0d]: valid=%b, required 0", k, rsp_valid);
            end
        end
        set_req(1, 8'd2, 8'd2, 4'b0000);
        req_valid = 4'b1010;
        #1;
        vectors++;
        if (req_ready !== 4'b0010) begin
            errors++;
            $display("FAIL midrst_ptr: ready=%b, required 0010", req_ready);
        end
        @(negedge clk);
        req_valid = 4'b0000;
        @(negedge clk);
        #1;
        vectors++;
        if (rsp_valid !== 1'b1 || rsp_data !== 16'h0004 || rsp_id !== 2'd1) begin
            errors++;
            $display("FAIL midrst_rsp: valid=%b data=%h id=%0d, required 1/0004/1",
                     rsp_valid, rsp_data, rsp_id);
        end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_back_to_back_stall();
        test_width_and_divzero();
        test_reset_mid_op();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
